// File: rtl/wrd_checker.sv
// Read-side checker for the storage read/write test: aligns read requests with returned data,
// checks data == address, tracks address sequence and sweep status.
// Optional first-error capture registers are built when WRD_CHK_FIRST_ERR_EN is defined.
module wrd_checker #(
  parameter int unsigned ADDR_WIDTH = 18,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned ERR_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic                  o_chk_valid,
  output logic                  o_chk_err,
  output logic                  o_seq_err,
  output logic [ERR_WIDTH-1:0]  o_err_cnt,
  output logic                  o_sweep_done,
  output logic                  o_sweep_ok,
  output logic [15:0]           o_sweep_cnt,
  output logic [ADDR_WIDTH-1:0] o_first_err_addr,
  output logic [DATA_WIDTH-1:0] o_first_err_data
);

  localparam int unsigned LastStage = RD_LATENCY - 1;

  typedef enum logic [0:0] {StIdle, StRun} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_last_addr;
  logic                  w_seq_err;

  logic                  r_pipe_vld  [RD_LATENCY];
  logic                  r_pipe_seq  [RD_LATENCY];
  logic [ADDR_WIDTH-1:0] r_pipe_addr [RD_LATENCY];

  logic                  w_out_vld;
  logic                  w_out_seq;
  logic [ADDR_WIDTH-1:0] w_out_addr;
  logic [DATA_WIDTH-1:0] w_exp_data;
  logic                  w_data_err;
  logic                  w_seq_hit;
  logic                  w_done;

  logic                  r_chk_valid;
  logic                  r_chk_err;
  logic                  r_seq_err;
  logic [ERR_WIDTH-1:0]  r_err_cnt;
  logic                  r_sweep_done;
  logic                  r_sweep_ok;
  logic [15:0]           r_sweep_cnt;
  logic                  r_sweep_flag;

  // The first request after IDLE seeds the reference; later ones must follow it by +1.
  assign w_seq_err = (r_state == StRun) && i_rd_en &&
                     (i_rd_addr != (r_last_addr + ADDR_WIDTH'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_last_addr <= '0;
    end else if (i_rd_en) begin
      r_state     <= StRun;
      r_last_addr <= i_rd_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
        r_pipe_vld[i]  <= 1'b0;
        r_pipe_seq[i]  <= 1'b0;
        r_pipe_addr[i] <= '0;
      end
    end else begin
      r_pipe_vld[0]  <= i_rd_en;
      r_pipe_seq[0]  <= w_seq_err;
      r_pipe_addr[0] <= i_rd_addr;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_seq[i]  <= r_pipe_seq[i-1];
        r_pipe_addr[i] <= r_pipe_addr[i-1];
      end
    end
  end

  assign w_out_vld  = r_pipe_vld[LastStage];
  assign w_out_seq  = r_pipe_seq[LastStage];
  assign w_out_addr = r_pipe_addr[LastStage];
  assign w_exp_data = DATA_WIDTH'(w_out_addr);
  assign w_data_err = w_out_vld && (i_rd_data != w_exp_data);
  assign w_seq_hit  = w_out_vld && w_out_seq;
  assign w_done     = w_out_vld && (w_out_addr == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chk_valid  <= 1'b0;
      r_chk_err    <= 1'b0;
      r_seq_err    <= 1'b0;
      r_err_cnt    <= '0;
      r_sweep_done <= 1'b0;
      r_sweep_ok   <= 1'b0;
      r_sweep_cnt  <= '0;
      r_sweep_flag <= 1'b0;
    end else begin
      r_chk_valid  <= w_out_vld;
      r_chk_err    <= w_data_err;
      r_seq_err    <= w_seq_hit;
      r_sweep_done <= w_done;
      r_sweep_ok   <= w_done && !(r_sweep_flag || w_data_err || w_seq_hit);
      if (w_done) begin
        r_sweep_flag <= 1'b0;
        r_sweep_cnt  <= r_sweep_cnt + 16'd1;
      end else if (w_data_err || w_seq_hit) begin
        r_sweep_flag <= 1'b1;
      end
      if (w_data_err && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + ERR_WIDTH'(1);
      end
    end
  end

  assign o_chk_valid  = r_chk_valid;
  assign o_chk_err    = r_chk_err;
  assign o_seq_err    = r_seq_err;
  assign o_err_cnt    = r_err_cnt;
  assign o_sweep_done = r_sweep_done;
  assign o_sweep_ok   = r_sweep_ok;
  assign o_sweep_cnt  = r_sweep_cnt;

`ifdef WRD_CHK_FIRST_ERR_EN
  logic                  r_first_seen;
  logic [ADDR_WIDTH-1:0] r_first_addr;
  logic [DATA_WIDTH-1:0] r_first_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_first_seen <= 1'b0;
      r_first_addr <= '0;
      r_first_data <= '0;
    end else if (w_data_err && !r_first_seen) begin
      r_first_seen <= 1'b1;
      r_first_addr <= w_out_addr;
      r_first_data <= i_rd_data;
    end
  end

  assign o_first_err_addr = r_first_addr;
  assign o_first_err_data = r_first_data;
`else
  assign o_first_err_addr = '0;
  assign o_first_err_data = '0;
`endif

endmodule

// File: tb/tb_wrd_checker.sv
// Bench for wrd_checker: two instances (latency 1 / err width 16, latency 3 / err width 2)
// share one request stream; an event-level model predicts every output each cycle.
module tb_wrd_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rd_en = 1'b0;
  logic [3:0] rd_addr = 4'h0;
  logic [7:0] rd_word = 8'h00;
  logic [7:0] dq [3];
  logic [7:0] mem [16];

  logic        cv0, ce0, se0, sd0, so0, cv1, ce1, se1, sd1, so1;
  logic [15:0] ec0, sc0, sc1;
  logic [1:0]  ec1;
  logic [3:0]  fa0, fa1;
  logic [7:0]  fd0, fd1;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
    bit         seq;
  } req_t;

  req_t       pend [int];
  bit         started;
  logic [3:0] last;
  int         m_cnt [2];
  int         m_scnt [2];
  bit         m_flag [2];
  bit         m_fe [2];
  logic [3:0] m_fa [2];
  logic [7:0] m_fd [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory under test: returns the word captured at request time after 1 or 3 cycles.
  always @(posedge clk) begin
    dq[0] <= rd_en ? rd_word : 8'($urandom);
    dq[1] <= dq[0];
    dq[2] <= dq[1];
  end

  wrd_checker #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .RD_LATENCY(1), .ERR_WIDTH(16)) u_dut_l1 (
    .clk(clk), .rst(rst), .i_rd_en(rd_en), .i_rd_addr(rd_addr), .i_rd_data(dq[0]),
    .o_chk_valid(cv0), .o_chk_err(ce0), .o_seq_err(se0), .o_err_cnt(ec0),
    .o_sweep_done(sd0), .o_sweep_ok(so0), .o_sweep_cnt(sc0),
    .o_first_err_addr(fa0), .o_first_err_data(fd0)
  );

  wrd_checker #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .RD_LATENCY(3), .ERR_WIDTH(2)) u_dut_l3 (
    .clk(clk), .rst(rst), .i_rd_en(rd_en), .i_rd_addr(rd_addr), .i_rd_data(dq[2]),
    .o_chk_valid(cv1), .o_chk_err(ce1), .o_seq_err(se1), .o_err_cnt(ec1),
    .o_sweep_done(sd1), .o_sweep_ok(so1), .o_sweep_cnt(sc1),
    .o_first_err_addr(fa1), .o_first_err_data(fd1)
  );

  function automatic int max_cnt(int d);
    return (d == 0) ? 65535 : 3;
  endfunction

  task automatic cmp(int d, string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL dut%0d %s observed %0h expected %0h cycle %0d", d, tag, obs, exp, cyc);
    end
  endtask

  task automatic check_dut(int d, logic cv, logic ce, logic se, logic sd, logic so,
                           logic [15:0] ec, logic [15:0] sc, logic [3:0] fa, logic [7:0] fd);
    bit   ev, e_err, e_seq, e_done, e_ok;
    req_t r;
    int   key;
    key = cyc * 2 + d;
    ev = 0; e_err = 0; e_seq = 0; e_done = 0; e_ok = 0;
    if (pend.exists(key)) begin
      r = pend[key];
      pend.delete(key);
      ev     = 1;
      e_err  = (r.data != {4'h0, r.addr});
      e_seq  = r.seq;
      e_done = (r.addr == 4'hF);
      e_ok   = e_done && !(m_flag[d] || e_err || e_seq);
      if (e_err && m_cnt[d] < max_cnt(d)) m_cnt[d]++;
      if (e_err && !m_fe[d]) begin
        m_fe[d] = 1; m_fa[d] = r.addr; m_fd[d] = r.data;
      end
      if (e_done) begin
        m_flag[d] = 0;
        m_scnt[d] = (m_scnt[d] + 1) % 65536;
      end else if (e_err || e_seq) begin
        m_flag[d] = 1;
      end
    end
    cmp(d, "chk_valid", 32'(cv), 32'(ev));
    cmp(d, "chk_err", 32'(ce), 32'(e_err));
    cmp(d, "seq_err", 32'(se), 32'(e_seq));
    cmp(d, "sweep_done", 32'(sd), 32'(e_done));
    cmp(d, "sweep_ok", 32'(so), 32'(e_ok));
    cmp(d, "err_cnt", 32'(ec), 32'(m_cnt[d]));
    cmp(d, "sweep_cnt", 32'(sc), 32'(m_scnt[d]));
`ifdef WRD_CHK_FIRST_ERR_EN
    cmp(d, "first_err_addr", 32'(fa), 32'(m_fa[d]));
    cmp(d, "first_err_data", 32'(fd), 32'(m_fd[d]));
`else
    cmp(d, "first_err_addr", 32'(fa), 32'h0);
    cmp(d, "first_err_data", 32'(fd), 32'h0);
`endif
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check_dut(0, cv0, ce0, se0, sd0, so0, ec0, sc0, fa0, fd0);
      check_dut(1, cv1, ce1, se1, sd1, so1, {14'h0, ec1}, sc1, fa1, fd1);
    end
  end

  task automatic model_clear();
    pend.delete();
    started = 0;
    last    = 4'h0;
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 0; m_scnt[d] = 0; m_flag[d] = 0; m_fe[d] = 0;
      m_fa[d] = 4'h0; m_fd[d] = 8'h00;
    end
  endtask

  task automatic step(bit en, logic [3:0] a, bit corrupt);
    req_t r;
    @(posedge clk); #1;
    rd_en   = en;
    rd_addr = a;
    rd_word = mem[a];
    if (corrupt) rd_word = mem[a] ^ 8'($urandom_range(1, 255));
    if (en) begin
      r.addr = a;
      r.data = rd_word;
      r.seq  = started && (a != last + 4'd1);
      started = 1;
      last    = a;
      pend[(cyc + 2) * 2 + 0] = r;
      pend[(cyc + 4) * 2 + 1] = r;
    end
  endtask

  task automatic reset_dut(int n);
    @(posedge clk); #1;
    rd_en = 1'b0;
    rst   = 1'b1;
    model_clear();
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic sweep(bit corrupt_every3);
    for (int i = 0; i < 16; i++) step(1'b1, 4'(i), corrupt_every3 && (i % 3 == 0));
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'($urandom), 1'b0);
  endtask

  initial begin
    logic [3:0] nxt;
    bit         en;
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    model_clear();
    #2 rst = 1'b1;
    chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(5);                          // reset state, no pulses while idle

    sweep(1'b0);                      // clean sweep
    idle(4);

    mem[5] = 8'hA5;                   // single corrupted location
    sweep(1'b0);
    mem[5] = 8'h05;
    idle(4);

    step(1'b1, 4'd0, 1'b0);           // skipped address 3
    step(1'b1, 4'd1, 1'b0);
    step(1'b1, 4'd2, 1'b0);
    for (int i = 4; i < 16; i++) step(1'b1, 4'(i), 1'b0);

    idle(16);                         // gaps across the 15 -> 0 wrap
    sweep(1'b0);
    idle(16);
    sweep(1'b0);
    idle(3);

    sweep(1'b1);                      // six mismatches: saturates the 2-bit counter
    idle(5);

    step(1'b1, 4'd3, 1'b0);           // reset lands while addr 3 is in flight
    reset_dut(2);
    idle(6);

    nxt = 4'($urandom);
    for (int i = 0; i < 300; i++) begin
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) nxt = 4'($urandom);
      step(en, en ? nxt : 4'($urandom), ($urandom_range(0, 7) == 0));
      if (en) nxt = nxt + 4'd1;
      if (i == 150) begin
        reset_dut(1);
        nxt = 4'($urandom);
      end
    end
    idle(8);

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
